// File: rtl/cl_pkg.sv
// Shared constants and state type for the code-length encoder.
// Sizes: 29 literal + 16 distance lengths, 4-bit symbols, 9 = zero-run escape.
package cl_pkg;

  localparam int         CL_NUM_LIT  = 29;
  localparam int         CL_NUM_DIST = 16;
  localparam int         CL_NUM      = 45;
  localparam logic [3:0] CL_ESC      = 4'd9;
  localparam logic [3:0] CL_MAX_LEN  = 4'd8;
  localparam int         CL_RUN_MIN  = 3;
  localparam int         CL_RUN_MAX  = 10;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    EMIT,
    ESC,
    FIN
  } cl_enc_state_t;

endpackage

// File: rtl/cl_zero_run.sv
// Zero-run lookahead: counts consecutive zero lengths starting at IP.
// Ports: i_win = buf[IP..IP+9] (entry k at [4k+3:4k]), i_ip, o_run = run capped at 10 and 45-IP.
module cl_zero_run
  import cl_pkg::*;
(
  input  logic [4*CL_RUN_MAX-1:0] i_win,
  input  logic [5:0]              i_ip,
  output logic [3:0]              o_run
);

  logic [6:0] w_left;
  logic       w_zero;

  always_comb begin
    w_left = 7'(CL_NUM) - {1'b0, i_ip};
    w_zero = 1'b1;
    o_run  = 4'd0;
    for (int k = 0; k < CL_RUN_MAX; k++) begin
      // window slots past entry 44 never extend the run
      w_zero = w_zero & (i_win[4*k +: 4] == 4'd0)
                      & (7'(k) < w_left);
      if (w_zero) o_run = o_run + 4'd1;
    end
  end

endmodule

// File: rtl/cl_encode.sv
// Code-length stream encoder: serialises 45 lengths as 4-bit FIFO symbols.
// Ports: clk, rst_n (sync, active-low), start, litTree, distTree, wfull in;
// winc, wdata, busy, done, err out. Macro CL_ZERO_RLE_EN enables zero-run escapes.
module cl_encode
  import cl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [4*CL_NUM_LIT-1:0]   litTree,
  input  logic [4*CL_NUM_DIST-1:0]  distTree,
  input  logic                      wfull,
  output logic                      winc,
  output logic [3:0]                wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  cl_enc_state_t       r_state;
  logic [4*CL_NUM-1:0] r_buf;
  logic [5:0]          r_ip;
  logic [3:0]          r_run_r;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [3:0]          w_cur;
  logic [3:0]          w_run;
  logic                w_esc;
  logic                w_bad;
  logic [5:0]          w_ip_nx;

  assign w_cur = 4'(r_buf >> {r_ip, 2'b00});

`ifdef CL_ZERO_RLE_EN
  logic [4*CL_RUN_MAX-1:0] w_win;

  assign w_win = (4*CL_RUN_MAX)'(r_buf >> {r_ip, 2'b00});

  cl_zero_run u_zero_run (
    .i_win (w_win),
    .i_ip  (r_ip),
    .o_run (w_run)
  );

  assign w_esc = (w_cur == 4'd0) && (w_run >= 4'(CL_RUN_MIN));
`else
  assign w_run = 4'd0;
  assign w_esc = 1'b0;
`endif

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < CL_NUM; i++) begin
      if (r_buf[4*i +: 4] > CL_MAX_LEN) w_bad = 1'b1;
    end
  end

  assign w_ip_nx = (r_state == ESC) ? r_ip + {2'b00, r_run_r}
                                    : r_ip + 6'd1;

  // winc/wdata are decoded straight from state so a full FIFO
  // blocks the write in the same cycle
  always_comb begin
    winc  = 1'b0;
    wdata = 4'd0;
    case (r_state)
      EMIT: begin
        winc  = !wfull;
        wdata = w_esc ? CL_ESC : w_cur;
      end
      ESC: begin
        winc  = !wfull;
        wdata = r_run_r - 4'(CL_RUN_MIN);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_ip    <= '0;
      r_run_r <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_buf   <= {distTree, litTree};
          r_ip    <= '0;
          r_busy  <= 1'b1;
          r_state <= CHECK;
        end
        CHECK: if (w_bad) begin
          r_err   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_state <= EMIT;
        end
        EMIT: if (!wfull) begin
          if (w_esc) begin
            r_run_r <= w_run;
            r_state <= ESC;
          end else begin
            r_ip <= w_ip_nx;
            if (w_ip_nx == 6'(CL_NUM)) begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end
        ESC: if (!wfull) begin
          r_ip <= w_ip_nx;
          if (w_ip_nx == 6'(CL_NUM)) begin
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_state <= EMIT;
          end
        end
        FIN: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_cl_encode.sv
// Self-checking bench for cl_encode: sequence-level model plus loopback decode.
// Honours CL_ZERO_RLE_EN the same way as the design.
module tb_cl_encode;

`ifdef CL_ZERO_RLE_EN
  localparam bit RLE = 1'b1;
`else
  localparam bit RLE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [115:0] litTree;
  logic [63:0]  distTree;
  logic         wfull;
  logic         winc;
  logic [3:0]   wdata;
  logic         busy;
  logic         done;
  logic         err;

  cl_encode dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .litTree  (litTree),
    .distTree (distTree),
    .wfull    (wfull),
    .winc     (winc),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] lens[45];
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int         writes;
  int         first_w;
  int         cyc;
  int         err_cnt;
  int         n_exp;
  bit         done_seen;
  bit         active = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, expv);
    end
  endtask

  // Greedy zero-run encoding of the length list
  task automatic model();
    int ip = 0;
    exp_q.delete();
    while (ip < 45) begin
      int z = 0;
      while (ip + z < 45 && z < 10 && lens[ip+z] == 4'd0) z++;
      if (RLE && z >= 3) begin
        exp_q.push_back(4'd9);
        exp_q.push_back(4'(z - 3));
        ip += z;
      end else begin
        exp_q.push_back(lens[ip]);
        ip++;
      end
    end
  endtask

  task automatic pack();
    for (int i = 0; i < 29; i++) litTree[4*i +: 4] = lens[i];
    for (int j = 0; j < 16; j++) distTree[4*j +: 4] = lens[29+j];
  endtask

  task automatic pin(input string nm, input logic [3:0] r[$]);
    int bad = 0;
    chk({nm, "_len"}, exp_q.size(), r.size());
    for (int i = 0; i < r.size() && i < exp_q.size(); i++)
      if (exp_q[i] !== r[i]) bad++;
    chk({nm, "_syms"}, bad, 0);
  endtask

  // Reconstruct the tree buffer as the extractor would
  task automatic loopback();
    logic [3:0] dec[45];
    int p = 0;
    int i = 0;
    int bad = 0;
    while (i < got_q.size()) begin
      if (RLE && got_q[i] == 4'd9 && i + 1 < got_q.size()) begin
        for (int k = 0; k < int'(got_q[i+1]) + 3; k++) begin
          if (p < 45) dec[p] = 4'd0;
          p++;
        end
        i += 2;
      end else begin
        if (p < 45) dec[p] = got_q[i];
        p++;
        i++;
      end
    end
    for (int k = 0; k < 45; k++)
      if (k >= p || dec[k] !== lens[k]) bad++;
    chk("loopback_len", p, 45);
    chk("loopback_mismatch", bad, 0);
  endtask

  always @(negedge clk) begin
    if (active) begin
      if (wfull) chk("winc_while_full", int'(winc), 0);
      if (!done_seen && !err && err_cnt == 0)
        chk("busy_during", int'(busy), 1);
      if (winc) begin
        if (first_w < 0) first_w = cyc;
        if (exp_q.size() == 0) begin
          chk("extra_write", 1, 0);
        end else begin
          chk("wdata", int'(wdata), int'(exp_q[0]));
          void'(exp_q.pop_front());
        end
        got_q.push_back(wdata);
        writes++;
      end
      if (done) done_seen = 1'b1;
      if (err) err_cnt++;
    end
  end

  // mode: 0 free, 1 random wfull, 2 stall 5 after 10 writes,
  // 3 stop after 10 writes, 4 restart attempt while busy
  task automatic encode(input int mode, input bit want_err);
    int stalled = 0;
    model();
    n_exp = exp_q.size();
    if (want_err) exp_q.delete();
    pack();
    got_q.delete();
    writes = 0;
    first_w = -1;
    done_seen = 1'b0;
    err_cnt = 0;
    cyc = 0;
    wfull = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    active = 1'b1;
    while (cyc < 600) begin
      if (mode == 3 && writes >= 10) break;
      wfull = 1'b0;
      start = 1'b0;
      if (mode == 1) wfull = ($urandom_range(0, 3) == 0);
      if (mode == 2 && writes >= 10 && stalled < 5) begin
        wfull = 1'b1;
        stalled++;
      end
      if (mode == 4 && cyc == 3) begin
        start = 1'b1;
        litTree = {29{4'h1}};
      end
      @(posedge clk); #1 cyc++;
      if (done_seen || err_cnt > 0) break;
    end
    wfull = 1'b0;
    start = 1'b0;
  endtask

  task automatic post();
    @(negedge clk);
    chk("done_seen", int'(done_seen), 1);
    chk("leftover", exp_q.size(), 0);
    chk("write_count", writes, n_exp);
    chk("busy_idle", int'(busy), 0);
    loopback();
    active = 1'b0;
  endtask

  initial begin
    logic [3:0] r[$];
    rst_n = 1'b0;
    start = 1'b0;
    wfull = 1'b0;
    litTree = '0;
    distTree = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_winc", int'(winc), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    foreach (lens[i]) lens[i] = 4'd5;
    encode(0, 1'b0);
    chk("first_write_edge", first_w + 1, 2);
    post();
    chk("all5_writes", writes, 45);

    foreach (lens[i]) lens[i] = 4'd0;
    model();
    r.delete();
    if (RLE) r = {4'd9, 4'd7, 4'd9, 4'd7, 4'd9, 4'd7, 4'd9, 4'd7, 4'd9, 4'd2};
    else for (int i = 0; i < 45; i++) r.push_back(4'd0);
    pin("pin_zeros", r);
    encode(0, 1'b0);
    post();

    foreach (lens[i]) lens[i] = (i == 2) ? 4'd3 : (i < 15 ? 4'd0 : 4'd1);
    model();
    r.delete();
    if (RLE) begin
      r = {4'd0, 4'd0, 4'd3, 4'd9, 4'd7, 4'd0, 4'd0};
      for (int i = 0; i < 30; i++) r.push_back(4'd1);
    end else begin
      for (int i = 0; i < 45; i++) r.push_back(lens[i]);
    end
    pin("pin_mixed", r);
    encode(0, 1'b0);
    post();

    foreach (lens[i]) lens[i] = 4'd5;
    encode(2, 1'b0);
    post();
    chk("stall_writes", writes, 45);

    lens[7] = 4'hA;
    encode(0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("err_pulses", err_cnt, 1);
    chk("err_writes", writes, 0);
    chk("err_busy", int'(busy), 0);
    chk("err_no_done", int'(done_seen), 0);
    active = 1'b0;

    foreach (lens[i]) lens[i] = 4'($urandom_range(0, 8));
    encode(4, 1'b0);
    post();

    for (int t = 0; t < 20; t++) begin
      foreach (lens[i])
        lens[i] = ($urandom_range(0, 2) != 0) ? 4'd0 : 4'($urandom_range(0, 8));
      encode(1, 1'b0);
      post();
    end

    foreach (lens[i]) lens[i] = (i % 7 == 0) ? 4'd0 : 4'($urandom_range(1, 8));
    encode(3, 1'b0);
    active = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_winc", int'(winc), 0);
    chk("midrst_busy", int'(busy), 0);
    encode(0, 1'b0);
    post();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
